// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file for the pipelined LEGv8 core.
// It has NREAD combinational read ports with write-to-read bypass, one write
// port and a hard-wired zero register. A per-register pending-write counter
// lets decode detect RAW hazards on the operands it actually consumes.
//
// Ports:
//   Clk, Resetb        clock, asynchronous active-low reset
//   RA, RdUse          packed read addresses, per-port operand-consumed flags
//   Bus                packed read data (combinational)
//   RW, BusW, RegWr    writeback address, data, enable
//   IssueVld, IssueRd  destination reservation from decode
//   Flush              discard all pending reservations
//   Stall              RAW hazard on some used read port (combinational)
//   IssueFull          reservation for IssueRd cannot be recorded (combinational)
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                    Clk,
    input  logic                    Resetb,
    input  logic [NREAD*ADDR_W-1:0] RA,
    input  logic [NREAD-1:0]        RdUse,
    output logic [NREAD*DATA_W-1:0] Bus,
    input  logic [ADDR_W-1:0]       RW,
    input  logic [DATA_W-1:0]       BusW,
    input  logic                    RegWr,
    input  logic                    IssueVld,
    input  logic [ADDR_W-1:0]       IssueRd,
    input  logic                    Flush,
    output logic                    Stall,
    output logic                    IssueFull
);

    localparam int unsigned       DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_REG);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [CNT_W-1:0]  r_pend [DEPTH];

    logic             w_wr_en;
    logic             w_issue_req;
    logic             w_inc;
    logic             w_dec;
    logic [NREAD-1:0] w_hazard;

    // Writes and reservations never target the zero register, so its
    // counter stays at its reset value of 0.
    assign w_wr_en     = RegWr && (RW != ZERO_A);
    assign w_issue_req = IssueVld && (IssueRd != ZERO_A);
    assign IssueFull   = w_issue_req && (r_pend[IssueRd] == CNT_MAX);
    assign w_inc       = w_issue_req && !IssueFull && !Flush;
    assign w_dec       = w_wr_en && (r_pend[RW] != '0);

    // Register array and scoreboard counters
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            r_regs <= '{default: '0};
            r_pend <= '{default: '0};
        end else begin
            if (w_wr_en) begin
                r_regs[RW] <= BusW;
            end
            if (Flush) begin
                r_pend <= '{default: '0};
            end else if (!(w_inc && w_dec && (IssueRd == RW))) begin
                // Increment and decrement of different registers both apply.
                if (w_inc) begin
                    r_pend[IssueRd] <= r_pend[IssueRd] + CNT_ONE;
                end
                if (w_dec) begin
                    r_pend[RW] <= r_pend[RW] - CNT_ONE;
                end
            end
        end
    end

    // Per-port read mux and hazard detect
    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [CNT_W-1:0]  w_pend;
        logic              w_byp;

        assign w_ra   = RA[g*ADDR_W +: ADDR_W];
        assign w_byp  = RegWr && (RW == w_ra);
        assign w_pend = (w_ra == ZERO_A) ? '0 : r_pend[w_ra];

        assign Bus[g*DATA_W +: DATA_W] = (w_ra == ZERO_A) ? '0 :
                                         w_byp            ? BusW :
                                                            r_regs[w_ra];

        // The last outstanding write landing now is covered by the bypass.
        assign w_hazard[g] = RdUse[g] && (w_ra != ZERO_A) && (w_pend != '0) &&
                             !(w_byp && (w_pend == CNT_ONE));
    end

    assign Stall = |w_hazard;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed, table-driven bench for regfile_scoreboard (default parameters).
module tb_regfile_scoreboard;

    logic        Clk;
    logic        Resetb;
    logic [9:0]  RA;
    logic [1:0]  RdUse;
    logic [127:0] Bus;
    logic [4:0]  RW;
    logic [63:0] BusW;
    logic        RegWr;
    logic        IssueVld;
    logic [4:0]  IssueRd;
    logic        Flush;
    logic        Stall;
    logic        IssueFull;

    regfile_scoreboard dut (
        .Clk      (Clk),
        .Resetb   (Resetb),
        .RA       (RA),
        .RdUse    (RdUse),
        .Bus      (Bus),
        .RW       (RW),
        .BusW     (BusW),
        .RegWr    (RegWr),
        .IssueVld (IssueVld),
        .IssueRd  (IssueRd),
        .Flush    (Flush),
        .Stall    (Stall),
        .IssueFull(IssueFull)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [1:0]  rduse;
        logic        regwr;
        logic [4:0]  rw;
        logic [63:0] busw;
        logic        iv;
        logic [4:0]  ird;
        logic        flush;
        logic [63:0] eb0;
        logic [63:0] eb1;
        logic        es;
        logic        ef;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [1:0] rduse, input logic regwr,
                                input logic [4:0] rw, input logic [63:0] busw,
                                input logic iv, input logic [4:0] ird,
                                input logic flush, input logic [63:0] eb0,
                                input logic [63:0] eb1, input logic es,
                                input logic ef);
        vec_t v;
        v.ra0 = ra0; v.ra1 = ra1; v.rduse = rduse; v.regwr = regwr;
        v.rw = rw; v.busw = busw; v.iv = iv; v.ird = ird; v.flush = flush;
        v.eb0 = eb0; v.eb1 = eb1; v.es = es; v.ef = ef;
        vecs.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        RA       = {v.ra1, v.ra0};
        RdUse    = v.rduse;
        RegWr    = v.regwr;
        RW       = v.rw;
        BusW     = v.busw;
        IssueVld = v.iv;
        IssueRd  = v.ird;
        Flush    = v.flush;
    endtask

    task automatic idle();
        RA = '0; RdUse = '0; RegWr = 1'b0; RW = '0; BusW = '0;
        IssueVld = 1'b0; IssueRd = '0; Flush = 1'b0;
    endtask

    // Watchdog: the bench must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Resetb = 1'b0;
        idle();

        //   ra0 ra1 use wr rw busw            iv ird fl  eb0             eb1          es ef
        // reset state, write X5, zero register
        add(5,  31, 0, 0, 0,  64'h0,           0, 0,  0, 64'h0,           64'h0,        0, 0);
        add(5,  31, 0, 1, 5,  64'hDEAD_BEEF,   0, 0,  0, 64'hDEAD_BEEF,   64'h0,        0, 0);
        add(5,  31, 0, 0, 0,  64'h0,           0, 0,  0, 64'hDEAD_BEEF,   64'h0,        0, 0);
        add(31, 5,  0, 1, 31, 64'h1234,        0, 0,  0, 64'h0,           64'hDEAD_BEEF,0, 0);
        add(31, 5,  0, 0, 0,  64'h0,           0, 0,  0, 64'h0,           64'hDEAD_BEEF,0, 0);
        // same-cycle bypass
        add(7,  7,  0, 0, 0,  64'h0,           0, 0,  0, 64'h0,           64'h0,        0, 0);
        add(7,  7,  0, 1, 7,  64'hAA,          0, 0,  0, 64'hAA,          64'hAA,       0, 0);
        add(7,  0,  0, 0, 0,  64'h0,           0, 0,  0, 64'hAA,          64'h0,        0, 0);
        // RAW on X3
        add(3,  0,  1, 0, 0,  64'h0,           1, 3,  0, 64'h0,           64'h0,        0, 0);
        add(3,  0,  1, 0, 0,  64'h0,           0, 0,  0, 64'h0,           64'h0,        1, 0);
        add(3,  0,  0, 0, 0,  64'h0,           0, 0,  0, 64'h0,           64'h0,        0, 0);
        add(3,  0,  1, 1, 3,  64'h33,          0, 0,  0, 64'h33,          64'h0,        0, 0);
        add(3,  0,  1, 0, 0,  64'h0,           0, 0,  0, 64'h33,          64'h0,        0, 0);
        // WAW counting on X4 (port 1)
        add(0,  4,  2, 0, 0,  64'h0,           1, 4,  0, 64'h0,           64'h0,        0, 0);
        add(0,  4,  2, 0, 0,  64'h0,           1, 4,  0, 64'h0,           64'h0,        1, 0);
        add(0,  4,  2, 0, 0,  64'h0,           1, 4,  0, 64'h0,           64'h0,        1, 0);
        add(0,  4,  2, 0, 0,  64'h0,           1, 4,  0, 64'h0,           64'h0,        1, 1);
        add(0,  4,  2, 1, 4,  64'h41,          0, 0,  0, 64'h0,           64'h41,       1, 0);
        add(0,  4,  2, 1, 4,  64'h42,          0, 0,  0, 64'h0,           64'h42,       1, 0);
        add(0,  4,  2, 1, 4,  64'h43,          0, 0,  0, 64'h0,           64'h43,       0, 0);
        add(0,  4,  2, 0, 0,  64'h0,           0, 0,  0, 64'h0,           64'h43,       0, 0);
        // zero register is never reserved
        add(31, 0,  1, 0, 0,  64'h0,           1, 31, 0, 64'h0,           64'h0,        0, 0);
        add(31, 0,  1, 0, 0,  64'h0,           0, 0,  0, 64'h0,           64'h0,        0, 0);
        // simultaneous issue/writeback on X9, flush, late writeback
        add(9,  0,  1, 0, 0,  64'h0,           1, 9,  0, 64'h0,           64'h0,        0, 0);
        add(9,  0,  1, 1, 9,  64'h99,          1, 9,  0, 64'h99,          64'h0,        0, 0);
        add(9,  0,  1, 0, 0,  64'h0,           0, 0,  0, 64'h99,          64'h0,        1, 0);
        add(9,  10, 1, 1, 10, 64'hA0,          1, 11, 1, 64'h99,          64'hA0,       1, 0);
        add(9,  11, 3, 0, 0,  64'h0,           0, 0,  0, 64'h99,          64'h0,        0, 0);
        add(9,  10, 1, 1, 9,  64'h9A,          0, 0,  0, 64'h9A,          64'hA0,       0, 0);
        add(9,  10, 1, 0, 0,  64'h0,           0, 0,  0, 64'h9A,          64'hA0,       0, 0);

        repeat (2) @(negedge Clk);
        #1;
        check("reset_stall", 64'(Stall), 64'h0);
        check("reset_full",  64'(IssueFull), 64'h0);
        Resetb = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge Clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_bus0", i),  Bus[63:0],        vecs[i].eb0);
            check($sformatf("v%0d_bus1", i),  Bus[127:64],      vecs[i].eb1);
            check($sformatf("v%0d_stall", i), 64'(Stall),       64'(vecs[i].es));
            check($sformatf("v%0d_full", i),  64'(IssueFull),   64'(vecs[i].ef));
        end

        // Mid-stream reset with pend[2]=2 and X2=0x55
        @(negedge Clk);
        idle();
        RegWr = 1'b1; RW = 5'd2; BusW = 64'h55;
        IssueVld = 1'b1; IssueRd = 5'd2;
        @(negedge Clk);
        RegWr = 1'b0;
        @(negedge Clk);
        IssueVld = 1'b0;
        RA = {5'd0, 5'd2}; RdUse = 2'b01;
        #1;
        check("pre_rst_stall", 64'(Stall), 64'h1);
        check("pre_rst_bus0",  Bus[63:0], 64'h55);
        IssueVld = 1'b1; IssueRd = 5'd2;
        #1;
        check("pre_rst_full",  64'(IssueFull), 64'h0);
        #1;
        Resetb = 1'b0;
        #1;
        check("rst_stall", 64'(Stall), 64'h0);
        check("rst_bus0",  Bus[63:0], 64'h0);
        check("rst_full",  64'(IssueFull), 64'h0);
        IssueVld = 1'b0;
        @(negedge Clk);
        Resetb = 1'b1;
        @(negedge Clk);
        #1;
        check("post_rst_stall", 64'(Stall), 64'h0);
        check("post_rst_bus0",  Bus[63:0], 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file for the pipelined LEGv8 core. It provides NREAD combinational read ports, one write port, a hard-wired zero register and same-cycle write-to-read bypass. A per-register pending-write scoreboard lets decode detect RAW hazards. It replaces the fixed 2-read/64-bit register file and takes over hazard detection for register operands.

## Interface
- DATA_W, 64, register and bus width
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- NREAD, 2, number of read ports (1..4)
- ZERO_REG, 31, index that always reads 0, is never written and is never pending
- CNT_W, 2, pending-write counter width; max in-flight writes per register = 2**CNT_W-1
- Clk  in  1  clock; all state updates on rising edge
- Resetb  in  1  asynchronous, active-low reset
- RA  in  NREAD*ADDR_W  read addresses; port i = RA[i*ADDR_W +: ADDR_W]
- RdUse  in  NREAD  port i operand is actually consumed (enables hazard check)
- Bus  out  NREAD*DATA_W  read data; port i = Bus[i*DATA_W +: DATA_W]
- RW  in  ADDR_W  write (writeback) address
- BusW  in  DATA_W  write data
- RegWr  in  1  write enable
- IssueVld  in  1  decode issues an instruction writing IssueRd
- IssueRd  in  ADDR_W  destination reserved by the issuing instruction
- Flush  in  1  pipeline flush; discard all pending reservations
- Stall  out  1  RAW hazard on some used read port
- IssueFull  out  1  reservation for IssueRd cannot be recorded

## Operation
- Reads are combinational and evaluated per port i in this priority order:
  - RA_i == ZERO_REG: Bus_i = 0.
  - RegWr && RW == RA_i: Bus_i = BusW (bypass).
  - Otherwise Bus_i = regs[RA_i].
- Write: at posedge, if RegWr && RW != ZERO_REG, regs[RW] <= BusW. A write to ZERO_REG is dropped.
- Scoreboard: one CNT_W-bit counter pend[r] per register; pend[ZERO_REG] is constant 0.
  - inc = IssueVld && IssueRd != ZERO_REG && !IssueFull && !Flush.
  - dec = RegWr && RW != ZERO_REG && pend[RW] != 0.
  - Same register with inc and dec in one cycle: counter unchanged. Otherwise +1 on inc, -1 on dec.
  - Writeback to a register with pend == 0 (e.g. after flush): the data is written, the counter stays 0 and does not underflow.
  - Flush at posedge: all counters <= 0, overriding inc/dec. The register write in that cycle still happens.
- IssueFull = IssueVld && IssueRd != ZERO_REG && pend[IssueRd] == max (combinational). While it is asserted the reservation is not recorded, and upstream must hold the instruction.
- Stall = OR over i of hazard_i, where hazard_i = RdUse_i && RA_i != ZERO_REG && pend[RA_i] != 0 && !(RegWr && RW == RA_i && pend[RA_i] == 1).
  - The last term means the final outstanding write is landing this cycle and the bypass covers it.
- Reset (Resetb low, any time, including mid-stream): all regs <= 0 and all pend <= 0 immediately. Consequently Bus = 0 (bypass excepted), Stall = 0 and IssueFull = 0 while no write or issue is applied.

## Timing
- Read latency is 0 cycles (combinational from RA, RW, RegWr and BusW).
- A write is visible through the bypass in the same cycle and from the array from the next cycle.
- A reservation issued at edge N makes Stall visible after edge N. It clears at the edge of the matching writeback, and Stall already drops during the writeback cycle.
- Stall and IssueFull are combinational and do not depend on Flush in the same cycle.
- Reset deassertion needs no synchronisation inside the block. State is held until the first rising edge after release.

## Test plan
- Reset, then write 0xDEAD_BEEF to X5, then read X5 on port 0 and X31 on port 1: Bus0 = 0xDEADBEEF, Bus1 = 0. A write of 0x1234 to X31 is ignored, and X31 still reads 0.
- Same-cycle bypass: RegWr=1, RW=7, BusW=0xAA, RA0=7: Bus0 = 0xAA in that cycle. Without the write the cycle before, the array value is 0.
- RAW: issue Rd=3, next cycle RA0=3 with RdUse0=1: Stall=1. During the writeback cycle to X3, Stall=0 and Bus0 = BusW. With RdUse0=0, Stall=0 throughout.
- WAW counting: issue Rd=4 three times: pend=3 and IssueFull=1 on a fourth issue to Rd=4. After one writeback Stall stays 1. After the third writeback Stall=0.
- Simultaneous issue and writeback to X9 with pend=1: pend stays 1 and Stall stays 1 next cycle. A Flush then gives pend=0 and Stall=0. A late writeback to X9 updates data with no underflow.
- Assert Resetb low mid-stream with pend[2]=2 and X2=0x55: Stall and pend clear immediately, and X2 reads 0 after release.
